// File: rtl/cache_pmem_arbiter_pkg.sv
// rtl/cache_pmem_arbiter_pkg.sv - shared types and constants for the cache/pmem arbiter
package cache_pmem_arbiter_pkg;

    localparam int LINE_BITS        = 256;
    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

    // Clear the byte-within-line offset so memory only ever sees line addresses
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_pmem_arbiter.sv
// rtl/cache_pmem_arbiter.sv - shares one line-wide memory port between I-cache and D-cache
module cache_pmem_arbiter
    import cache_pmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [31:0]          i_pmem_address,
    input  logic                 i_pmem_read,
    output logic [LINE_BITS-1:0] i_pmem_rdata,
    output logic                 i_pmem_resp,

    input  logic [31:0]          d_pmem_address,
    input  logic                 d_pmem_read,
    input  logic                 d_pmem_write,
    input  logic [LINE_BITS-1:0] d_pmem_wdata,
    output logic [LINE_BITS-1:0] d_pmem_rdata,
    output logic                 d_pmem_resp,

    output logic [31:0]          mem_address,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_resp
);

    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [3:0] CNT_MAX = 4'd15;

    arb_state_t state;
    logic [3:0] starve_cnt;

    logic    i_req;
    logic    d_req;
    logic    grant_i;
    arb_op_t d_op;

    // Request decode and grant decision; starvation counter overrides D priority
    always_comb begin
        i_req   = i_pmem_read;
        d_req   = d_pmem_read | d_pmem_write;
        grant_i = i_req && (!d_req || (starve_cnt >= LIMIT));
        // A simultaneous read+write from the D-cache resolves to the write-back
        d_op    = d_pmem_write ? OP_WRITE : OP_READ;
    end

    // Responses are steered only to the owner of the outstanding transaction
    always_comb begin
        i_pmem_rdata = mem_rdata;
        d_pmem_rdata = mem_rdata;
        i_pmem_resp  = mem_resp && (state == SERVE_I);
        d_pmem_resp  = mem_resp && (state == SERVE_D);
    end

    // Arbitration FSM with registered memory-port outputs and starvation tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            mem_address <= 32'd0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state       <= SERVE_I;
                        mem_address <= line_align(i_pmem_address);
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        starve_cnt  <= 4'd0;
                    end else if (d_req) begin
                        state       <= SERVE_D;
                        mem_address <= line_align(d_pmem_address);
                        mem_read    <= (d_op == OP_READ);
                        mem_write   <= (d_op == OP_WRITE);
                        mem_wdata   <= d_pmem_wdata;
                        if (i_req) begin
                            if (starve_cnt != CNT_MAX) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else begin
                            starve_cnt <= 4'd0;
                        end
                    end else begin
                        starve_cnt <= 4'd0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Hold the transaction regardless of what the requester does now
                    if (mem_resp) begin
                        state     <= RECOVER;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                RECOVER: begin
                    // Dead cycle lets the cache retire its miss before re-arbitration
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // D-cache must never request a read and a write-back in the same cycle
    assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write));

    // Memory must only complete a transaction that is actually outstanding
    assert property (@(posedge clk) disable iff (rst)
                     mem_resp |-> (state == SERVE_I || state == SERVE_D));

endmodule
